// File: rtl/throttle_ctrl.sv
// Programmable clock throttle: divides CLK_50 by a power-of-two step chosen
// with two debounced push-buttons, producing a 50 % slow clock and a tick.
`timescale 1ns/1ps
module throttle_ctrl #(
  parameter int COUNTER_SIZE    = 24,
  parameter int NUM_STEPS       = 8,
  parameter int FREQ_W          = 3,
  parameter int RESET_STEP      = 0,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              CLK_50,
  input  logic              reset,
  input  logic              pb_freq_up,
  input  logic              pb_freq_dn,
  output logic              slow_clk,
  output logic              slow_tick,
  output logic [FREQ_W-1:0] freq_num
);

  localparam int              DW        = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0]   DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FREQ_W-1:0] TOP_STEP  = FREQ_W'(NUM_STEPS - 1);
  localparam logic [FREQ_W-1:0] INIT_STEP = FREQ_W'(RESET_STEP);

  // Half of P(s); P itself can need one bit more than the counter holds.
  function automatic logic [COUNTER_SIZE-1:0] half_period(input logic [FREQ_W-1:0] s);
    return COUNTER_SIZE'(1) << (COUNTER_SIZE - 1 - int'(s));
  endfunction

  localparam logic [COUNTER_SIZE-1:0] INIT_HALF = half_period(INIT_STEP);
  localparam logic [COUNTER_SIZE-1:0] INIT_CNT  = (INIT_HALF << 1) - COUNTER_SIZE'(1);

  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    accepted;
  logic [1:0]    accepted_d;
  logic [1:0]    press;
  logic [DW-1:0] deb_cnt [2];

  assign raw = {pb_freq_dn, pb_freq_up};

  // Bit 0 is the up button, bit 1 the down button.
  always_ff @(posedge CLK_50) begin
    if (!reset) begin
      sync1      <= '0;
      sync2      <= '0;
      accepted   <= '0;
      accepted_d <= '0;
      press      <= '0;
      for (int i = 0; i < 2; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync1      <= raw;
      sync2      <= sync1;
      accepted_d <= accepted;
      press      <= accepted & ~accepted_d;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == accepted[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          accepted[i] <= sync2[i];
          deb_cnt[i]  <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK_50) begin
    if (!reset) begin
      freq_num <= INIT_STEP;
    end else if (press[0] && !press[1]) begin
      if (freq_num < TOP_STEP) freq_num <= freq_num + FREQ_W'(1);
    end else if (press[1] && !press[0]) begin
      if (freq_num != '0) freq_num <= freq_num - FREQ_W'(1);
    end
  end

  logic [COUNTER_SIZE-1:0] cnt;
  logic [COUNTER_SIZE-1:0] half_active;
  logic [COUNTER_SIZE-1:0] cnt_next;
  logic [COUNTER_SIZE-1:0] half_next;

  // The period is latched only at reload, so step changes never cut a period short.
  always_comb begin
    cnt_next  = cnt - COUNTER_SIZE'(1);
    half_next = half_active;
    if (cnt == '0) begin
      half_next = half_period(freq_num);
      cnt_next  = (half_next << 1) - COUNTER_SIZE'(1);
    end
  end

  always_ff @(posedge CLK_50) begin
    if (!reset) begin
      cnt         <= INIT_CNT;
      half_active <= INIT_HALF;
      slow_clk    <= 1'b1;
    end else begin
      cnt         <= cnt_next;
      half_active <= half_next;
      slow_clk    <= (cnt_next >= half_next);
    end
  end

  assign slow_tick = (cnt == '0);

endmodule

// File: tb/tb_throttle_ctrl.sv
// Randomised and directed bench for throttle_ctrl against a period/run-length
// reference model of the divider and button paths.
`timescale 1ns/1ps
module tb_throttle_ctrl;

  localparam int CS  = 6;
  localparam int NS  = 4;
  localparam int FW  = 2;
  localparam int RS  = 0;
  localparam int DEB = 4;

  logic          CLK_50     = 1'b0;
  logic          reset      = 1'b0;
  logic          pb_freq_up = 1'b0;
  logic          pb_freq_dn = 1'b0;
  logic          slow_clk;
  logic          slow_tick;
  logic [FW-1:0] freq_num;

  int checks = 0;
  int errors = 0;

  // Reference model state, in spec cycle numbering (cycle n = values seen by edge n).
  int n;
  int start;
  int per;
  int freq;
  int acc_u, acc_d;
  int run_u, run_d;
  int due_u, due_d;
  bit up_hist[$];
  bit dn_hist[$];

  always #5 CLK_50 = ~CLK_50;

  throttle_ctrl #(
    .COUNTER_SIZE   (CS),
    .NUM_STEPS      (NS),
    .FREQ_W         (FW),
    .RESET_STEP     (RS),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .CLK_50    (CLK_50),
    .reset     (reset),
    .pb_freq_up(pb_freq_up),
    .pb_freq_dn(pb_freq_dn),
    .slow_clk  (slow_clk),
    .slow_tick (slow_tick),
    .freq_num  (freq_num)
  );

  function automatic int period_of(int s);
    return 1 << (CS - s);
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, observed, expected);
    end
  endtask

  task automatic model_reset();
    n     = 0;
    start = 0;
    per   = period_of(RS);
    freq  = RS;
    acc_u = 0; acc_d = 0;
    run_u = 0; run_d = 0;
    due_u = -1; due_d = -1;
    up_hist.delete();
    dn_hist.delete();
  endtask

  // An accepted level flips once the synchronised level has disagreed for DEB cycles.
  task automatic debounce(input int r, inout int acc, inout int run, inout int due);
    run = (r != acc) ? run + 1 : 0;
    if (run == DEB) begin
      acc = r;
      run = 0;
      if (r == 1) due = n + 2;
    end
  endtask

  task automatic model_edge(input bit up, input bit dn);
    if (n - start == per - 1) begin
      start = n + 1;
      per   = period_of(freq);
    end
    if (due_u == n && due_d != n) freq = (freq < NS - 1) ? freq + 1 : freq;
    else if (due_d == n && due_u != n) freq = (freq > 0) ? freq - 1 : 0;
    up_hist.push_back(up);
    dn_hist.push_back(dn);
    debounce((n >= 2) ? int'(up_hist[n-2]) : 0, acc_u, run_u, due_u);
    debounce((n >= 2) ? int'(dn_hist[n-2]) : 0, acc_d, run_d, due_d);
    n++;
  endtask

  task automatic check_cycle();
    int pos;
    pos = n - start;
    checkOutput("slow_tick", slow_tick, (pos == per - 1) ? 1 : 0);
    checkOutput("slow_clk",  slow_clk,  (pos < per / 2) ? 1 : 0);
    checkOutput("freq_num",  freq_num,  freq);
  endtask

  task automatic applyStimulus(input bit up, input bit dn, input int cycles);
    repeat (cycles) begin
      @(negedge CLK_50);
      check_cycle();
      pb_freq_up = up;
      pb_freq_dn = dn;
      @(posedge CLK_50);
      model_edge(up, dn);
    end
  endtask

  task automatic press(input bit up, input bit dn);
    applyStimulus(up, dn, 8);
    applyStimulus(0, 0, 10);
  endtask

  task automatic expect_step(input string tag, input int step);
    #1 checkOutput(tag, freq_num, step);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge CLK_50);
    reset      = 1'b0;
    pb_freq_up = 1'b0;
    pb_freq_dn = 1'b0;
    repeat (cycles) @(posedge CLK_50);
    @(negedge CLK_50);
    checkOutput("rst_freq", freq_num, RS);
    checkOutput("rst_clk",  slow_clk, 1);
    checkOutput("rst_tick", slow_tick, 0);
    @(posedge CLK_50);
    #1 reset = 1'b1;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit found;
    int cnt_m;
    model_reset();
    do_reset(3);

    // Free run, then a single up press held from cycle 10.
    applyStimulus(0, 0, 200);
    do_reset(2);
    applyStimulus(0, 0, 10);
    applyStimulus(1, 0, 20);
    expect_step("up_once", 1);
    applyStimulus(0, 0, 150);

    // Bounce rejection, then saturation both ways.
    repeat (4) begin
      applyStimulus(1, 0, 3);
      applyStimulus(0, 0, 3);
    end
    expect_step("bounce", 1);
    press(1, 0); expect_step("up_2", 2);
    press(1, 0); expect_step("up_3", 3);
    press(1, 0); expect_step("up_sat", 3);
    applyStimulus(0, 0, 40);
    press(0, 1); expect_step("dn_2", 2);
    press(0, 1); expect_step("dn_1", 1);
    press(0, 1); expect_step("dn_0", 0);
    press(0, 1); expect_step("dn_sat", 0);

    // Simultaneous presses at step 2, then down alone.
    press(1, 0);
    press(1, 0);
    applyStimulus(1, 1, 20);
    applyStimulus(0, 0, 20);
    expect_step("both", 2);
    press(0, 1); expect_step("dn_alone", 1);

    // Long hold gives exactly one step.
    applyStimulus(1, 0, 200);
    expect_step("hold", 2);
    applyStimulus(0, 0, 10);
    press(1, 0); expect_step("hold_again", 3);

    // Reset at cnt=5 of a step-2 period with an up press being debounced.
    press(0, 1);
    applyStimulus(0, 0, 40);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      cnt_m = per - 1 - (n - start);
      if (per == 16 && cnt_m == 5 && run_u > 0) found = 1;
      else applyStimulus((cnt_m <= 8 && cnt_m >= 6) ? 1'b1 : 1'b0, 0, 1);
    end
    checkOutput("reset_window", found ? 1 : 0, 1);
    do_reset(1);
    applyStimulus(0, 0, 80);
    expect_step("no_residual", 0);

    // Random button activity.
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 12));
    end
    applyStimulus(0, 0, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
